// File: rtl/cpu_cache_pkg.sv
// Shared FSM state type and address field slicing for the cpu_cache slice.
package cpu_cache_pkg;
  localparam int DATA_W  = 32;
  localparam int INDEX_W = 6;
  localparam int OFF_W   = 2;
  localparam int TAG_W   = 24;
  localparam int NSETS   = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} cache_state_e;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [DATA_W-1:0] a);
    return a[OFF_W +: INDEX_W];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [DATA_W-1:0] a);
    return a[DATA_W-1 -: TAG_W];
  endfunction
endpackage

// File: rtl/cpu_cache_way.sv
// One cache way: tag RAM, data RAM and valid flops with a 1-cycle read and one write port.
module cache_way
  import cpu_cache_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data
);
  logic [TAG_W-1:0]  tag_mem  [NSETS];
  logic [DATA_W-1:0] data_mem [NSETS];
  logic [NSETS-1:0]  valid;

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
    rd_tag  <= tag_mem[rd_idx];
    rd_data <= data_mem[rd_idx];
  end

  // Valid bits live in flops so clr can wipe every set in one cycle.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (we) valid[wr_idx] <= 1'b1;
      rd_valid <= valid[rd_idx];
    end
  end
endmodule

// File: rtl/cpu_cache.sv
// 2-way set-associative write-through cache with a stalling bus-master FSM.
// Define CACHE_DEBUG_EN to expose write enables, hit and RAM observation ports.
//
// state | meaning
// IDLE  | lookup of the current request; hits complete here
// REQ   | bus_dma raised, waiting for bus_grant
// XFER  | granted, driving bus address/direction, waiting for bus_ready
// DONE  | transfer finished, ready held until the CPU releases stall
module cpu_cache
  import cpu_cache_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              stall,
  input  logic [DATA_W-1:0] next_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              req,
  input  logic              rw,
  input  logic              bypass,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [DATA_W-1:0] addr,
  inout  wire  [DATA_W-1:0] bus_addr,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic              bus_dma,
  inout  wire               bus_rw,
  input  logic              bus_grant,
  input  logic              bus_ready
`ifdef CACHE_DEBUG_EN
  ,
  output logic              we_a,
  output logic              we_b,
  output logic              we_c,
  output logic              needupdate,
  output logic [TAG_W-1:0]  tag,
  output logic              hitA,
  output logic              hitB,
  output logic [DATA_W-1:0] ram_a_out
`endif
);
  cache_state_e      state;
  logic [DATA_W-1:0] wdata_r, cap_data;
  logic              req_r, rw_r, bypass_r;
  logic [NSETS-1:0]  lru;
  logic [INDEX_W-1:0] rd_idx, cur_idx;
  logic [TAG_W-1:0]  cur_tag, tag_a, tag_b;
  logic [DATA_W-1:0] data_a, data_b, wr_data;
  logic              valid_a, valid_b, hit_a, hit_b, hit;
  logic              drive, xfer_done, fill, upd, read_hit;
  logic              wr_a, wr_b, wr_lru, lru_next, need_fill;

  always_ff @(posedge clk) begin
    if (clr) begin
      addr     <= '0;
      req_r    <= 1'b0;
      rw_r     <= 1'b0;
      bypass_r <= 1'b0;
    end else if (!stall) begin
      addr     <= next_addr;
      wdata_r  <= wdata;
      req_r    <= req;
      rw_r     <= rw;
      bypass_r <= bypass;
    end
  end

  // While stalled the RAMs keep re-reading the current set so hit stays valid.
  assign rd_idx  = stall ? addr_index(addr) : addr_index(next_addr);
  assign cur_idx = addr_index(addr);
  assign cur_tag = addr_tag(addr);

  assign hit_a = valid_a && (tag_a == cur_tag);
  assign hit_b = valid_b && (tag_b == cur_tag);
  assign hit   = hit_a || hit_b;

  assign xfer_done = (state == XFER) && bus_grant && bus_ready && !clr;
  assign fill      = xfer_done && !rw_r && !bypass_r;
  assign upd       = xfer_done && rw_r && !bypass_r && hit;
  assign read_hit  = (state == IDLE) && req_r && !rw_r && !bypass_r && hit && !clr;

  // The fill lands as the word arrives, so a request latched on leaving DONE sees it.
  assign wr_a     = fill ? !lru[cur_idx] : (upd && hit_a);
  assign wr_b     = fill ?  lru[cur_idx] : (upd && hit_b && !hit_a);
  assign wr_data  = rw_r ? wdata_r : bus_data;
  assign wr_lru   = read_hit || fill || upd;
  assign lru_next = fill ? !lru[cur_idx] : hit_a;
  assign need_fill = ((state == REQ) || (state == XFER)) && !rw_r && !bypass_r;

  cache_way u_way_a (
    .clk(clk), .clr(clr), .rd_idx(rd_idx), .we(wr_a), .wr_idx(cur_idx),
    .wr_tag(cur_tag), .wr_data(wr_data),
    .rd_valid(valid_a), .rd_tag(tag_a), .rd_data(data_a)
  );

  cache_way u_way_b (
    .clk(clk), .clr(clr), .rd_idx(rd_idx), .we(wr_b), .wr_idx(cur_idx),
    .wr_tag(cur_tag), .wr_data(wr_data),
    .rd_valid(valid_b), .rd_tag(tag_b), .rd_data(data_b)
  );

  always_ff @(posedge clk) begin
    if (clr) lru <= '0;
    else if (wr_lru) lru[cur_idx] <= lru_next;
  end

  always_ff @(posedge clk) begin
    if (xfer_done) cap_data <= bus_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      bus_dma <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_r && (rw_r || bypass_r || !hit)) begin
          state   <= REQ;
          bus_dma <= 1'b1;
        end
        REQ:  if (bus_grant) state <= XFER;
        XFER: if (bus_grant && bus_ready) begin
          state   <= DONE;
          bus_dma <= 1'b0;
        end
        DONE: if (!stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready = !clr && (!req_r || (state == DONE) || read_hit);
  assign rdata = (state == DONE) ? cap_data : (hit_b ? data_b : data_a);

  assign drive    = (state == XFER) && bus_grant;
  assign bus_addr = drive ? addr : {DATA_W{1'bz}};
  assign bus_rw   = drive ? rw_r : 1'bz;
  assign bus_data = (drive && rw_r) ? wdata_r : {DATA_W{1'bz}};

`ifdef CACHE_DEBUG_EN
  assign we_a       = wr_a;
  assign we_b       = wr_b;
  assign we_c       = wr_lru;
  assign needupdate = need_fill;
  assign tag        = cur_tag;
  assign hitA       = hit_a;
  assign hitB       = hit_b;
  assign ram_a_out  = data_a;
`else
  logic unused_dbg;
  assign unused_dbg = need_fill;
`endif
endmodule

// File: tb/tb_cpu_cache.sv
// Directed bench for cpu_cache acting as CPU and as arbiter/bus slave.
module tb_cpu_cache;
  logic        clk, clr, stall, req, rw, bypass, bus_grant, bus_ready;
  logic [31:0] next_addr, wdata, rdata, addr;
  logic        ready, bus_dma;
  wire  [31:0] bus_addr, bus_data;
  wire         bus_rw;
  logic        sdrive;
  logic [31:0] sdata;

  int tests = 0;
  int fails = 0;
  logic        used, ok, brw;
  logic [31:0] rd, baddr, bdata;

  assign bus_data = sdrive ? sdata : 32'hz;

  cpu_cache dut (
    .clk(clk), .clr(clr), .stall(stall), .next_addr(next_addr), .wdata(wdata),
    .req(req), .rw(rw), .bypass(bypass), .rdata(rdata), .ready(ready), .addr(addr),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_dma(bus_dma), .bus_rw(bus_rw),
    .bus_grant(bus_grant), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1; req = 0; stall = 0; next_addr = 0; bus_grant = 0; bus_ready = 0; sdrive = 0;
    @(negedge clk);
    chk("clr_ready", {31'd0, ready}, 0);
    chk("clr_dma", {31'd0, bus_dma}, 0);
    clr = 0;
  endtask

  // Issue one request (call at a negedge where the previous one is ready) and serve the bus.
  task automatic access(input logic [31:0] a, input logic w, input logic b,
                        input logic [31:0] d, input logic [31:0] resp, input string name);
    next_addr = a; rw = w; bypass = b; wdata = d; req = 1; stall = 0;
    @(posedge clk); #1;
    stall = 1; req = 0;
    chk({name, "_addr"}, addr, a);
    used = 0; ok = 0; baddr = '0; brw = 0; bdata = '0; rd = '0; sdata = resp;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_ready) begin bus_ready = 0; bus_grant = 0; sdrive = 0; end
      if (ready) begin rd = rdata; ok = 1; break; end
      if (bus_dma && !bus_grant) begin
        bus_grant = 1; used = 1;
      end else if (bus_grant) begin
        baddr = bus_addr; brw = bus_rw; bdata = bus_data;
        sdrive = !bus_rw; bus_ready = 1;
      end
    end
    chk({name, "_done"}, {31'd0, ok}, 1);
    if (used) chk({name, "_dma_drop"}, {31'd0, bus_dma}, 0);
  endtask

  initial begin
    clk = 0; clr = 0; stall = 0; next_addr = 0; wdata = 0; req = 0; rw = 0; bypass = 0;
    bus_grant = 0; bus_ready = 0; sdrive = 0; sdata = 0;

    do_clr();
    access(32'd0, 0, 0, 0, 32'h1111_0000, "rd0_miss");
    chk("rd0_bus", {31'd0, used}, 1);
    chk("rd0_baddr", baddr, 32'd0);
    chk("rd0_rw", {31'd0, brw}, 0);
    chk("rd0_data", rd, 32'h1111_0000);
    access(32'd0, 0, 0, 0, 32'hffff_ffff, "rd0_hit");
    chk("rd0_hit_bus", {31'd0, used}, 0);
    chk("rd0_hit_data", rd, 32'h1111_0000);

    access(32'd4,  0, 0, 0, 32'h0000_0a04, "rd4");  chk("rd4_bus",  {31'd0, used}, 1);
    access(32'd28, 0, 0, 0, 32'h0000_0a28, "rd28"); chk("rd28_bus", {31'd0, used}, 1);
    chk("rd28_baddr", baddr, 32'd28);
    access(32'd8,  0, 0, 0, 32'h0000_0a08, "rd8");  chk("rd8_bus",  {31'd0, used}, 1);
    access(32'd16, 0, 0, 0, 32'h0000_0a16, "rd16"); chk("rd16_bus", {31'd0, used}, 1);
    chk("rd16_data", rd, 32'h0000_0a16);
    access(32'd4,  0, 0, 0, 32'hffff_ffff, "rd4_hit");
    chk("rd4_hit_bus", {31'd0, used}, 0);
    chk("rd4_hit_data", rd, 32'h0000_0a04);

    access(32'd24, 0, 0, 0, 32'h0000_0024, "rd24");
    access(32'd24, 1, 0, 32'h0ab2_1128, 32'h0, "wr24");
    chk("wr24_bus", {31'd0, used}, 1);
    chk("wr24_baddr", baddr, 32'd24);
    chk("wr24_rw", {31'd0, brw}, 1);
    chk("wr24_bdata", bdata, 32'h0ab2_1128);
    access(32'd24, 0, 0, 0, 32'hffff_ffff, "rd24_hit");
    chk("rd24_hit_bus", {31'd0, used}, 0);
    chk("rd24_hit_data", rd, 32'h0ab2_1128);
    access(32'd40, 1, 0, 32'h1234_5678, 32'h0, "wr40");
    access(32'd40, 0, 0, 0, 32'h0000_0040, "rd40");
    chk("wr40_no_alloc", {31'd0, used}, 1);
    chk("rd40_data", rd, 32'h0000_0040);

    do_clr();
    access(32'd0,   0, 0, 0, 32'hc000_0000, "lru0");   chk("lru0_bus",   {31'd0, used}, 1);
    access(32'd256, 0, 0, 0, 32'hc000_0256, "lru256"); chk("lru256_bus", {31'd0, used}, 1);
    access(32'd512, 0, 0, 0, 32'hc000_0512, "lru512"); chk("lru512_bus", {31'd0, used}, 1);
    access(32'd256, 0, 0, 0, 32'hffff_ffff, "lru256_hit");
    chk("lru256_hit_bus", {31'd0, used}, 0);
    chk("lru256_hit_data", rd, 32'hc000_0256);
    access(32'd0,   0, 0, 0, 32'hc000_1000, "lru0_evicted");
    chk("lru0_evicted_bus", {31'd0, used}, 1);

    do_clr();
    access(32'd4,   0, 0, 0, 32'hb000_0004, "bp4");
    access(32'd260, 0, 0, 0, 32'hb000_0260, "bp260");
    access(32'd4,   0, 0, 0, 32'hffff_ffff, "bp4_hit");
    chk("bp4_hit_bus", {31'd0, used}, 0);
    access(32'd4,   0, 1, 0, 32'h0000_beef, "bypass4");
    chk("bypass4_bus", {31'd0, used}, 1);
    chk("bypass4_baddr", baddr, 32'd4);
    chk("bypass4_data", rd, 32'h0000_beef);
    access(32'd516, 0, 0, 0, 32'hb000_0516, "bp516");
    chk("bp516_bus", {31'd0, used}, 1);
    access(32'd4,   0, 0, 0, 32'hffff_ffff, "bp4_after");
    chk("bp4_after_bus", {31'd0, used}, 0);
    chk("bp4_after_data", rd, 32'hb000_0004);

    do_clr();
    next_addr = 32'd64; rw = 0; bypass = 0; req = 1; stall = 0;
    @(posedge clk); #1;
    stall = 1; req = 0;
    @(negedge clk);
    chk("abort_ready_idle", {31'd0, ready}, 0);
    @(negedge clk);
    chk("abort_dma_req", {31'd0, bus_dma}, 1);
    bus_grant = 1;
    @(negedge clk);
    chk("abort_baddr", bus_addr, 32'd64);
    clr = 1;
    @(negedge clk);
    chk("abort_dma_drop", {31'd0, bus_dma}, 0);
    chk("abort_ready", {31'd0, ready}, 0);
    tests++;
    assert (bus_addr !== 32'd64) else begin
      fails++;
      $error("FAIL abort_bus_release: observed %h expected not %h", bus_addr, 32'd64);
    end
    clr = 0; bus_grant = 0;
    @(negedge clk);
    chk("abort_ready_after", {31'd0, ready}, 1);
    access(32'd64, 0, 0, 0, 32'h0000_0064, "abort_reread");
    chk("abort_no_fill", {31'd0, used}, 1);
    chk("abort_reread_data", rd, 32'h0000_0064);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
